exa_vc_tx: RTL and testbench
============================

# exa_vc_tx

Credit-based virtual-channel transmitter: the read end of a bank of per-VC `exa_fifo` instances (show-ahead, `ALL_REGD=1`) feeding one switch output link. It keeps one downstream credit counter per VC and picks a VC round-robin among those with data and credit. It then drains a whole packet (word-granular credits, `last`-framed) onto a valid/ready link before it re-arbitrates. It sits between the output-queue FIFOs and the link serializer; the remote receiver returns credits on `i_credit_ret`.

## Interface
- `NUM_VC`, default 2: number of virtual channels (≥2).
- `DWIDTH`, default 32: link payload width. Each FIFO word is `{last, data}`, `DWIDTH+1` bits.
- `CREDITS`, default 16: initial and maximum credits per VC (the downstream buffer depth in words).
- Derived `CWIDTH = $clog2(CREDITS+1)`, `VCW = $clog2(NUM_VC)`.

Ports:
- `clk` in, 1: clock.
- `arst_n` in, 1: reset, asynchronous, active-low.
- `i_fifo_data` in, `NUM_VC*(DWIDTH+1)`: head word of each VC FIFO. VC v occupies bits `[v*(DWIDTH+1) +: DWIDTH+1]`; the MSB is `last`.
- `i_fifo_empty` in, `NUM_VC`: empty flag per FIFO.
- `o_fifo_rd_en` out, `NUM_VC`: pop strobe per FIFO, one-hot or zero.
- `o_tx_valid` out, 1: link word valid.
- `o_tx_data` out, `DWIDTH`: link payload.
- `o_tx_last` out, 1: last word of packet.
- `o_tx_vc` out, `VCW`: VC of the current word.
- `i_tx_ready` in, 1: link accepts the word.
- `i_credit_ret` in, `NUM_VC`: one-cycle pulse returns one word credit to VC v. Several bits may pulse in the same cycle.
- `o_credit_cnt` out, `NUM_VC*CWIDTH`: current credit count per VC.
- `o_credit_err` out, 1: sticky flag, set on credit overflow.

## Operation
- `req[v] = ~i_fifo_empty[v] & (credit[v] != 0)`.
- FSM, two states:
  - **IDLE**: if any `req` is set, the round-robin arbiter grants the first requesting VC at or after `rr_ptr`. The grant is registered into `gnt_vc` and the FSM goes to SEND. If no `req` is set, stay in IDLE. Nothing is transmitted in IDLE.
  - **SEND**: `o_tx_valid = ~i_fifo_empty[gnt_vc] & (credit[gnt_vc] != 0)`. `o_tx_data`/`o_tx_last` are taken from `i_fifo_data[gnt_vc]`, and `o_tx_vc = gnt_vc`. A word transfers when `o_tx_valid & i_tx_ready`; on transfer, `o_fifo_rd_en[gnt_vc]=1` and `credit[gnt_vc]` is decremented. If the transferred word has `last` set, the FSM goes to IDLE and `rr_ptr <= gnt_vc+1` (mod `NUM_VC`).
- The VC stays locked in SEND. If the locked VC runs empty or out of credit mid-packet, `o_tx_valid` drops and the FSM holds; no other VC is interleaved.
- Credit update per VC, each cycle: `next = credit + ret - consume`.
  - Simultaneous return and consume leaves the count unchanged.
  - If `next > CREDITS`, the counter saturates at `CREDITS` and `o_credit_err` is set. `o_credit_err` clears only on reset.
- `o_tx_valid` must never assert with zero credit on the granted VC.
- `o_tx_data` must not change while `o_tx_valid=1 & i_tx_ready=0`. This holds because the FIFO head is stable until it is popped.

## Timing
- Reset values:
  - FSM = IDLE, `gnt_vc=0`, `rr_ptr=0`.
  - `credit[v]=CREDITS` for all v; `o_credit_err=0`.
  - `o_tx_valid=0`, `o_fifo_rd_en=0`.
  - `o_tx_data`/`o_tx_last`/`o_tx_vc` are don't-care (implementation drives `gnt_vc=0`'s head).
- Reset mid-packet aborts the packet. The FIFOs are reset by the same `arst_n`.
- Arbitration latency: 1 cycle. With `req` seen at cycle t, the first word can be valid at t+1. This gives a one-cycle bubble per packet; throughput is 1 word/cycle within a packet.
- `o_tx_valid`, `o_tx_data`, `o_tx_last`, `o_fifo_rd_en` are combinational from registered state and the FIFO outputs (registered in `exa_fifo`) plus `i_tx_ready`. `o_fifo_rd_en` depends combinationally on `i_tx_ready`.
- A credit returned at cycle t is visible in `credit` and `o_credit_cnt` at t+1 and usable at t+1.
- The FIFO pop at cycle t presents the new head at t+1; a back-to-back burst is supported.

## Structure
- Package `exa_vc_tx_pkg`:
  - state enum `tx_state_e {TX_IDLE, TX_SEND}`;
  - function `credit_width(int credits)`;
  - word-slicing localparams (`LAST_BIT = DWIDTH`).
- Sub-module `exa_rr_arbiter #(N)`:
  - inputs: `req[N]`, `ptr`;
  - outputs: one-hot `gnt[N]`, binary `gnt_idx`, `any`;
  - purely combinational, reused by other output ports.
- Credit counters are a generate loop inside `exa_vc_tx`.
- Target size: about 200 lines.

## Test plan
- **Single packet**: VC0 holds a 3-word packet (last on word 3), `ready=1`, CREDITS=16 → IDLE 1 cycle, then 3 consecutive valid words with `o_tx_vc=0` and `last` on the third; `credit[0]=13`; 3 pulses on `o_fifo_rd_en[0]`.
- **Round-robin**: VC0 and VC1 each hold two 2-word packets → transmit order VC0, VC1, VC0, VC1, with one idle cycle between packets.
- **Credit stall**: CREDITS=2, VC1 holds a 4-word packet, no returns → 2 words sent, then valid drops and the FSM holds VC1. A VC0 packet present meanwhile is not sent. One `i_credit_ret[1]` pulse → the next word is valid the cycle after.
- **Backpressure**: hold `i_tx_ready=0` for 5 cycles mid-packet → data and last stable, no `rd_en`, credit unchanged.
- **Simultaneous**: word transfer on VC0 in the same cycle as `i_credit_ret[0]` → `credit[0]` unchanged. An extra return with credit already at 16 → count stays 16 and `o_credit_err=1` (sticky).
- **Reset mid-packet**: assert `arst_n` low during word 2 of 4 → next cycle `o_tx_valid=0`, all credits 16, `o_credit_err=0`, FSM IDLE.

Source files
------------

// File: rtl/exa_vc_tx_pkg.sv
// Shared types and helpers for the credit-based VC transmitter.
package exa_vc_tx_pkg;

  // Transmit FSM: wait for a grant, or stream one packet from the locked VC.
  typedef enum logic [0:0] {
    TX_IDLE = 1'b0,
    TX_SEND = 1'b1
  } tx_state_e;

  // Counter width able to hold 0..credits inclusive.
  function automatic int credit_width(input int credits);
    return $clog2(credits + 1);
  endfunction

  // FIFO word is {last, data}; last sits just above the payload.
  function automatic int word_width(input int dwidth);
    return dwidth + 1;
  endfunction

endpackage

// File: rtl/exa_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr.
module exa_rr_arbiter #(
  parameter int N  = 2,
  localparam int VW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [VW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [VW-1:0] gnt_idx,
  output logic          any
);

  // Scan the requesters in rotated order starting at ptr; the first hit wins.
  always_comb begin
    int k;
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    k       = 0;
    for (int i = 0; i < N; i++) begin
      k = (int'(ptr) + i) % N;
      if (!any && req[k]) begin
        any     = 1'b1;
        gnt[k]  = 1'b1;
        gnt_idx = VW'(k);
      end
    end
  end

endmodule

// File: rtl/exa_vc_tx.sv
// Credit-based virtual-channel transmitter: drains whole packets from per-VC
// show-ahead FIFOs onto one valid/ready link, round-robin between packets.
module exa_vc_tx
  import exa_vc_tx_pkg::*;
#(
  parameter int  NUM_VC  = 2,
  parameter int  DWIDTH  = 32,
  parameter int  CREDITS = 16,
  localparam int CWIDTH  = credit_width(CREDITS),
  localparam int VCW     = $clog2(NUM_VC)
) (
  input  logic                             clk,
  input  logic                             arst_n,
  input  logic [NUM_VC*(DWIDTH+1)-1:0]     i_fifo_data,
  input  logic [NUM_VC-1:0]                i_fifo_empty,
  output logic [NUM_VC-1:0]                o_fifo_rd_en,
  output logic                             o_tx_valid,
  output logic [DWIDTH-1:0]                o_tx_data,
  output logic                             o_tx_last,
  output logic [VCW-1:0]                   o_tx_vc,
  input  logic                             i_tx_ready,
  input  logic [NUM_VC-1:0]                i_credit_ret,
  output logic [NUM_VC*CWIDTH-1:0]         o_credit_cnt,
  output logic                             o_credit_err
);

  localparam int                WORD_W     = word_width(DWIDTH);
  localparam int                LAST_BIT   = DWIDTH;
  localparam logic [CWIDTH-1:0] CREDIT_MAX = CWIDTH'(CREDITS);

  tx_state_e         state;
  logic [VCW-1:0]    gnt_vc;
  logic [NUM_VC-1:0] gnt_oh;
  logic [VCW-1:0]    rr_ptr;
  logic [VCW-1:0]    rr_next;

  logic [NUM_VC-1:0] has_credit;
  logic [NUM_VC-1:0] req;
  logic [NUM_VC-1:0] ovf;
  logic [NUM_VC-1:0] arb_gnt;
  logic [VCW-1:0]    arb_idx;
  logic              arb_any;

  logic [WORD_W-1:0] head;
  logic              tx_valid;
  logic              xfer;

  assign req = ~i_fifo_empty & has_credit;

  exa_rr_arbiter #(.N(NUM_VC)) u_arb (
    .req     (req),
    .ptr     (rr_ptr),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .any     (arb_any)
  );

  // Link side: the locked VC's FIFO head goes straight out; a word moves only
  // when it exists, a downstream credit is available and the link accepts it.
  assign head         = i_fifo_data[int'(gnt_vc)*WORD_W +: WORD_W];
  assign tx_valid     = (state == TX_SEND) && !i_fifo_empty[gnt_vc] && has_credit[gnt_vc];
  assign xfer         = tx_valid && i_tx_ready;
  assign o_tx_valid   = tx_valid;
  assign o_tx_data    = head[DWIDTH-1:0];
  assign o_tx_last    = head[LAST_BIT];
  assign o_tx_vc      = gnt_vc;
  assign o_fifo_rd_en = xfer ? gnt_oh : '0;

  assign rr_next = (gnt_vc == VCW'(NUM_VC - 1)) ? '0 : gnt_vc + 1'b1;

  // Packet FSM: latch the arbiter's grant in IDLE, release it after the last word.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state  <= TX_IDLE;
      gnt_vc <= '0;
      gnt_oh <= NUM_VC'(1);
      rr_ptr <= '0;
    end else begin
      case (state)
        TX_IDLE: begin
          if (arb_any) begin
            gnt_vc <= arb_idx;
            gnt_oh <= arb_gnt;
            state  <= TX_SEND;
          end
        end
        TX_SEND: begin
          if (xfer && head[LAST_BIT]) begin
            state  <= TX_IDLE;
            rr_ptr <= rr_next;
          end
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

  for (genvar v = 0; v < NUM_VC; v++) begin : g_credit
    logic [CWIDTH-1:0] cnt;
    logic [CWIDTH:0]   nxt;

    // One spare bit so a return on a full counter is visible as overflow.
    assign nxt = {1'b0, cnt}
               + {{CWIDTH{1'b0}}, i_credit_ret[v]}
               - {{CWIDTH{1'b0}}, o_fifo_rd_en[v]};
    assign ovf[v]        = (nxt > {1'b0, CREDIT_MAX});
    assign has_credit[v] = (cnt != '0);
    assign o_credit_cnt[v*CWIDTH +: CWIDTH] = cnt;

    // Per-VC word credit: returns add, transfers consume, saturate at the maximum.
    always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
        cnt <= CREDIT_MAX;
      end else begin
        cnt <= ovf[v] ? CREDIT_MAX : nxt[CWIDTH-1:0];
      end
    end
  end

  // Sticky overflow flag: any VC receiving more credit than it can hold.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      o_credit_err <= 1'b0;
    end else if (|ovf) begin
      o_credit_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_exa_vc_tx.sv
// Directed bench for exa_vc_tx with a behavioural show-ahead FIFO per VC.
module tb_exa_vc_tx;

  localparam int NV = 2;
  localparam int DW = 32;
  localparam int CR = 16;
  localparam int CW = 5;
  localparam int WW = DW + 1;

  logic              clk = 1'b0;
  logic              arst_n = 1'b0;
  logic [NV*WW-1:0]  fifo_data;
  logic [NV-1:0]     fifo_empty;
  logic [NV-1:0]     fifo_rd_en;
  logic              tx_valid;
  logic [DW-1:0]     tx_data;
  logic              tx_last;
  logic              tx_vc;
  logic              tx_ready = 1'b0;
  logic [NV-1:0]     credit_ret = '0;
  logic [NV*CW-1:0]  credit_cnt;
  logic              credit_err;

  logic [WW-1:0]     q0[$];
  logic [WW-1:0]     q1[$];
  logic [NV-1:0]     snap;
  int                n_assert = 0;
  int                n_fail = 0;

  always #5 clk = ~clk;

  exa_vc_tx #(.NUM_VC(NV), .DWIDTH(DW), .CREDITS(CR)) dut (
    .clk          (clk),
    .arst_n       (arst_n),
    .i_fifo_data  (fifo_data),
    .i_fifo_empty (fifo_empty),
    .o_fifo_rd_en (fifo_rd_en),
    .o_tx_valid   (tx_valid),
    .o_tx_data    (tx_data),
    .o_tx_last    (tx_last),
    .o_tx_vc      (tx_vc),
    .i_tx_ready   (tx_ready),
    .i_credit_ret (credit_ret),
    .o_credit_cnt (credit_cnt),
    .o_credit_err (credit_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    fifo_empty[0] = (q0.size() == 0);
    fifo_empty[1] = (q1.size() == 0);
    fifo_data[0*WW +: WW] = (q0.size() == 0) ? '0 : q0[0];
    fifo_data[1*WW +: WW] = (q1.size() == 0) ? '0 : q1[0];
  endtask

  task automatic push_pkt(input int vc, input int n, input int base);
    logic [WW-1:0] w;
    for (int i = 0; i < n; i++) begin
      w = {(i == n - 1), 32'(base + i)};
      if (vc == 0) q0.push_back(w);
      else         q1.push_back(w);
    end
    refresh();
  endtask

  // Advance one clock; the FIFO model pops on the strobe seen before the edge.
  task automatic tick();
    #1;
    snap = fifo_rd_en;
    @(posedge clk);
    #1;
    if (snap[0] && q0.size() > 0) void'(q0.pop_front());
    if (snap[1] && q1.size() > 0) void'(q1.pop_front());
    refresh();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [63:0] cnt_of(input int v);
    return 64'(credit_cnt[v*CW +: CW]);
  endfunction

  task automatic expw(input string tag, input int vc, input int data, input logic last);
    chk({tag, ".valid"}, 64'(tx_valid), 64'd1);
    chk({tag, ".vc"},    64'(tx_vc),    64'(vc));
    chk({tag, ".data"},  64'(tx_data),  64'(data));
    chk({tag, ".last"},  64'(tx_last),  64'(last));
    chk({tag, ".rd_en"}, 64'(fifo_rd_en), 64'(1 << vc));
    tick();
  endtask

  task automatic expidle(input string tag);
    chk({tag, ".valid"}, 64'(tx_valid), 64'd0);
    chk({tag, ".rd_en"}, 64'(fifo_rd_en), 64'd0);
    tick();
  endtask

  task automatic do_reset(input string tag);
    arst_n = 1'b0;
    q0.delete();
    q1.delete();
    tx_ready = 1'b0;
    credit_ret = '0;
    refresh();
    #1;
    chk({tag, ".valid"}, 64'(tx_valid), 64'd0);
    chk({tag, ".rd_en"}, 64'(fifo_rd_en), 64'd0);
    chk({tag, ".cnt"},   64'(credit_cnt), 64'h210);
    chk({tag, ".err"},   64'(credit_err), 64'd0);
    tick();
    chk({tag, ".valid_next"}, 64'(tx_valid), 64'd0);
    arst_n = 1'b1;
    tx_ready = 1'b1;
    #1;
  endtask

  initial begin
    refresh();
    @(negedge clk);
    #1;
    do_reset("rst0");

    // Single 3-word packet on VC0.
    push_pkt(0, 3, 'hA0);
    #1;
    expidle("single.idle");
    expw("single.w0", 0, 'hA0, 1'b0);
    expw("single.w1", 0, 'hA1, 1'b0);
    expw("single.w2", 0, 'hA2, 1'b1);
    chk("single.after_valid", 64'(tx_valid), 64'd0);
    chk("single.cnt0", cnt_of(0), 64'd13);
    chk("single.cnt1", cnt_of(1), 64'd16);

    // Round-robin between two VCs, two packets each.
    do_reset("rst1");
    push_pkt(0, 2, 'hB0);
    push_pkt(0, 2, 'hB2);
    push_pkt(1, 2, 'hC0);
    push_pkt(1, 2, 'hC2);
    #1;
    for (int p = 0; p < 4; p++) begin
      expidle($sformatf("rr.p%0d.idle", p));
      if (p % 2 == 0) begin
        expw($sformatf("rr.p%0d.w0", p), 0, 'hB0 + p, 1'b0);
        expw($sformatf("rr.p%0d.w1", p), 0, 'hB1 + p, 1'b1);
      end else begin
        expw($sformatf("rr.p%0d.w0", p), 1, 'hC0 + p - 1, 1'b0);
        expw($sformatf("rr.p%0d.w1", p), 1, 'hC1 + p - 1, 1'b1);
      end
    end
    chk("rr.idle_end", 64'(tx_valid), 64'd0);
    chk("rr.cnt", 64'(credit_cnt), {54'd0, 5'd12, 5'd12});

    // Credit stall: VC1 runs out of credit mid-packet and stays locked.
    do_reset("rst2");
    push_pkt(1, 18, 'h100);
    #1;
    expidle("stall.idle");
    for (int i = 0; i < 16; i++) expw($sformatf("stall.w%0d", i), 1, 'h100 + i, 1'b0);
    push_pkt(0, 2, 'h200);
    #1;
    chk("stall.valid", 64'(tx_valid), 64'd0);
    chk("stall.rd_en", 64'(fifo_rd_en), 64'd0);
    chk("stall.vc", 64'(tx_vc), 64'd1);
    chk("stall.cnt1", cnt_of(1), 64'd0);
    tick();
    tick();
    chk("stall.hold_valid", 64'(tx_valid), 64'd0);
    chk("stall.hold_vc", 64'(tx_vc), 64'd1);
    chk("stall.hold_rd_en", 64'(fifo_rd_en), 64'd0);
    credit_ret = 2'b10;
    tick();
    credit_ret = '0;
    #1;
    chk("stall.ret_cnt1", cnt_of(1), 64'd1);
    expw("stall.w16", 1, 'h110, 1'b0);
    chk("stall.dry_valid", 64'(tx_valid), 64'd0);
    credit_ret = 2'b10;
    tick();
    credit_ret = '0;
    #1;
    expw("stall.w17", 1, 'h111, 1'b1);
    expidle("stall.idle2");
    expw("stall.vc0w0", 0, 'h200, 1'b0);
    expw("stall.vc0w1", 0, 'h201, 1'b1);
    chk("stall.cnt0", cnt_of(0), 64'd14);
    chk("stall.cnt1_end", cnt_of(1), 64'd0);

    // Backpressure: ready low for five cycles in the middle of a packet.
    do_reset("rst3");
    push_pkt(0, 4, 'hE0);
    #1;
    expidle("bp.idle");
    expw("bp.w0", 0, 'hE0, 1'b0);
    expw("bp.w1", 0, 'hE1, 1'b0);
    tx_ready = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp.hold%0d.valid", i), 64'(tx_valid), 64'd1);
      chk($sformatf("bp.hold%0d.data", i), 64'(tx_data), 64'hE2);
      chk($sformatf("bp.hold%0d.last", i), 64'(tx_last), 64'd0);
      chk($sformatf("bp.hold%0d.rd_en", i), 64'(fifo_rd_en), 64'd0);
      chk($sformatf("bp.hold%0d.cnt0", i), cnt_of(0), 64'd14);
      tick();
    end
    tx_ready = 1'b1;
    #1;
    expw("bp.w2", 0, 'hE2, 1'b0);
    expw("bp.w3", 0, 'hE3, 1'b1);
    chk("bp.cnt0", cnt_of(0), 64'd12);

    // Simultaneous return and consume, then overflow on a full counter.
    do_reset("rst4");
    push_pkt(0, 2, 'hF0);
    #1;
    expidle("sim.idle");
    credit_ret = 2'b01;
    #1;
    expw("sim.w0", 0, 'hF0, 1'b0);
    credit_ret = '0;
    #1;
    chk("sim.cnt0_same", cnt_of(0), 64'd16);
    chk("sim.err_clear", 64'(credit_err), 64'd0);
    expw("sim.w1", 0, 'hF1, 1'b1);
    chk("sim.cnt0_dec", cnt_of(0), 64'd15);
    credit_ret = 2'b10;
    tick();
    credit_ret = '0;
    #1;
    chk("sim.cnt1_sat", cnt_of(1), 64'd16);
    chk("sim.err_set", 64'(credit_err), 64'd1);
    chk("sim.cnt0_keep", cnt_of(0), 64'd15);
    tick();
    tick();
    chk("sim.err_sticky", 64'(credit_err), 64'd1);

    // Reset in the middle of a 4-word packet.
    push_pkt(0, 4, 'h300);
    #1;
    expidle("mid.idle");
    expw("mid.w0", 0, 'h300, 1'b0);
    chk("mid.w1.valid", 64'(tx_valid), 64'd1);
    chk("mid.w1.data", 64'(tx_data), 64'h301);
    do_reset("mid.rst");
    chk("mid.after.valid", 64'(tx_valid), 64'd0);
    chk("mid.after.cnt", 64'(credit_cnt), 64'h210);
    chk("mid.after.err", 64'(credit_err), 64'd0);
    tick();
    chk("mid.idle_hold", 64'(tx_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
